// File: rtl/ice_rx_framer_if.sv
// ice_rx_framer_if
//   Header and payload handshake bundle between ice_rx_framer and the
//   command dispatcher.
//   master : the framer (drives header fields, payload stream, valids)
//   slave  : the dispatcher (drives hdr_ready / pl_ready)
//   Signals:
//     hdr_valid/hdr_ready      header handshake
//     hdr_type/hdr_id/hdr_len  frame header bytes
//     pl_valid/pl_ready        payload byte handshake
//     pl_data/pl_last          payload byte and end-of-frame marker
interface ice_rx_framer_if;
  logic       hdr_valid;
  logic       hdr_ready;
  logic [7:0] hdr_type;
  logic [7:0] hdr_id;
  logic [7:0] hdr_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       pl_last;

  modport master (
    output hdr_valid, hdr_type, hdr_id, hdr_len,
    output pl_valid, pl_data, pl_last,
    input  hdr_ready, pl_ready
  );

  modport slave (
    input  hdr_valid, hdr_type, hdr_id, hdr_len,
    input  pl_valid, pl_data, pl_last,
    output hdr_ready, pl_ready
  );
endinterface

// File: rtl/ice_rx_framer.sv
// ice_rx_framer
//   Splits the host UART byte stream into ICE frames laid out as
//   [type][event_id][len][payload x len]. The header is held in a one-deep
//   register slot; payload bytes go through a first-word fall-through FIFO
//   tagged with an end-of-frame bit.
//   Optional: define ICE_RX_TIMEOUT_EN to abandon frames that stall for
//   TIMEOUT_CYCLES clocks (timeout_err pulses); otherwise the parser waits
//   indefinitely and timeout_err is tied low.
//   Ports:
//     clk, reset       clock, asynchronous active-low reset
//     rx_data/rx_latch received byte and its one-cycle strobe
//     rx_if            header + payload handshakes (master side)
//     ovf_err          sticky drop indicator, cleared by err_clr
//     timeout_err      one-cycle pulse when a stalled frame is abandoned
module ice_rx_framer #(
  parameter int FIFO_DEPTH     = 64,
  parameter int FIFO_AW        = 6,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_latch,
  ice_rx_framer_if.master  rx_if,
  output logic             ovf_err,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_ID  = 3'd1;
  localparam logic [2:0] GET_LEN = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] DROP    = 3'd4;

  logic [2:0]         state;
  logic [7:0]         type_q;
  logic [7:0]         id_q;
  logic [7:0]         rem;
  logic               tmo_fire;
  logic               byte_in;
  logic               hdr_busy;
  logic               len_take;
  logic               hdr_load;
  logic               hdr_drop;

  logic [8:0]         mem [FIFO_DEPTH];
  logic [8:0]         head;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_full;
  logic               push_req;
  logic               push_ok;
  logic               push_ovf;
  logic               pop;

  // A byte arriving on the timeout edge starts a new frame instead.
  assign byte_in  = rx_latch & ~tmo_fire;
  assign hdr_busy = rx_if.hdr_valid & ~rx_if.hdr_ready;
  assign len_take = byte_in & (state == GET_LEN);
  assign hdr_load = len_take & ~hdr_busy;
  assign hdr_drop = len_take & hdr_busy;

  assign fifo_full = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop       = rx_if.pl_valid & rx_if.pl_ready;
  assign push_req  = byte_in & (state == PAYLOAD);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req & (~fifo_full | pop);
  assign push_ovf  = push_req & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      type_q <= '0;
      id_q   <= '0;
      rem    <= '0;
    end else if (tmo_fire) begin
      state <= rx_latch ? GET_ID : IDLE;
      if (rx_latch) type_q <= rx_data;
    end else if (rx_latch) begin
      case (state)
        IDLE: begin
          type_q <= rx_data;
          state  <= GET_ID;
        end
        GET_ID: begin
          id_q  <= rx_data;
          state <= GET_LEN;
        end
        GET_LEN: begin
          rem <= rx_data;
          if (rx_data == '0) state <= IDLE;
          else               state <= hdr_busy ? DROP : PAYLOAD;
        end
        PAYLOAD, DROP: begin
          rem <= rem - 8'd1;
          if (rem == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_if.hdr_valid <= 1'b0;
      rx_if.hdr_type  <= '0;
      rx_if.hdr_id    <= '0;
      rx_if.hdr_len   <= '0;
    end else if (hdr_load) begin
      rx_if.hdr_valid <= 1'b1;
      rx_if.hdr_type  <= type_q;
      rx_if.hdr_id    <= id_q;
      rx_if.hdr_len   <= rx_data;
    end else if (rx_if.hdr_valid && rx_if.hdr_ready) begin
      rx_if.hdr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     ovf_err <= 1'b0;
    else if (hdr_drop || push_ovf)  ovf_err <= 1'b1;
    else if (err_clr)               ovf_err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {(rem == 8'd1), rx_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs read as zero while empty so the reset/empty view is clean.
  assign head           = mem[rd_ptr];
  assign rx_if.pl_valid = (count != '0);
  assign rx_if.pl_data  = rx_if.pl_valid ? head[7:0] : '0;
  assign rx_if.pl_last  = rx_if.pl_valid & head[8];

`ifdef ICE_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  assign tmo_fire = (state != IDLE) && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_fire;
      if (rx_latch || state == IDLE) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)   tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/ice_rx_framer.md
Name: ice_rx_framer

Overview:
- Sits directly downstream of the ICE UART receiver. Consumes the byte stream the host sends over USB_UART.
- Delineates ICE frames with byte layout [type][event_id][len][payload × len].
- Presents the frame header on a valid/ready port, and the payload on a buffered valid/ready byte stream, to the command dispatcher in m3_ice_top.
- Detects overflow and stalled frames so a lost byte cannot desynchronise the parser.

Parameters:
- FIFO_DEPTH, 64: payload FIFO entries; power of two, 4..256.
- FIFO_AW, 6: log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 8192: idle clk cycles inside a frame before the frame is abandoned (used only with ICE_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rx_data  in  8  received byte from uart; valid only while rx_latch=1.
- rx_latch  in  1  one-cycle pulse per received byte; no back-pressure possible.
- hdr_valid  out  1  header registers hold an unconsumed header.
- hdr_ready  in  1  dispatcher accepts the header when hdr_valid&hdr_ready.
- hdr_type  out  8  frame type byte.
- hdr_id  out  8  frame event_id byte.
- hdr_len  out  8  payload length, 0..255.
- pl_valid  out  1  pl_data is valid.
- pl_ready  in  1  consumer pops when pl_valid&pl_ready.
- pl_data  out  8  payload byte.
- pl_last  out  1  pl_data is the final byte of its frame.
- ovf_err  out  1  sticky: header or payload dropped for lack of space.
- timeout_err  out  1  one-cycle pulse when an in-progress frame is abandoned.
- err_clr  in  1  synchronous clear of ovf_err.

Behaviour:
- Reset (async, reset=0):
  - State becomes IDLE; FIFO pointers and count are 0; timeout counter is 0.
  - hdr_valid, pl_valid, pl_last, ovf_err and timeout_err are 0.
  - hdr_type, hdr_id, hdr_len and pl_data are 0.
  - A frame in progress is discarded; nothing is resumed after reset.
- FSM states: IDLE, GET_ID, GET_LEN, PAYLOAD, DROP. All transitions occur only on rx_latch, except timeout.
  - IDLE: byte goes to type_q -> GET_ID.
  - GET_ID: byte goes to id_q -> GET_LEN.
  - GET_LEN: byte goes to len_q; remaining counter rem = byte.
    - If hdr_valid=1 and not being accepted this same cycle: set ovf_err; if len=0 -> IDLE, else -> DROP.
    - Otherwise load hdr_* and set hdr_valid on the next edge (1-cycle latency after the len byte). Then go to IDLE if len=0, else PAYLOAD.
  - PAYLOAD: each byte is pushed with last=(rem==1), then rem decrements. When rem reaches 0 -> IDLE.
    - FIFO full on a push: byte dropped, ovf_err set, rem still decrements; the frame is not re-synchronised.
  - DROP: discard bytes while decrementing rem; when rem reaches 0 -> IDLE.
- Header handshake:
  - hdr_valid clears on the edge where hdr_valid&hdr_ready.
  - Accepting a header and loading a new one in the same cycle is legal; the new header wins and hdr_valid stays 1.
- Payload FIFO: 9 bits wide (data + last), first-word fall-through.
  - A byte pushed at edge N into an empty FIFO gives pl_valid=1 after edge N (visible from cycle N+1).
  - Simultaneous push and pop when full: the pop frees the slot, so the push succeeds with no overflow.
  - Simultaneous push and pop when empty: the pushed byte appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits.
- ovf_err:
  - Set-dominant over err_clr when both occur in the same cycle.
  - Otherwise err_clr=1 clears it on the next edge.
- The header for a frame may be consumed before, during or after its payload. Ordering between frames is preserved.

Optional Feature:
- Macro: ICE_RX_TIMEOUT_EN.
- Defined:
  - The counter resets to 0 on every rx_latch and whenever state is IDLE; otherwise it increments, saturating.
  - When it reaches TIMEOUT_CYCLES in a non-IDLE state: go to IDLE and pulse timeout_err for 1 cycle.
  - A header already loaded stays valid. Payload bytes already in the FIFO stay, but the frame has no pl_last.
  - An rx_latch in the same cycle as the timeout is treated as a type byte (state becomes GET_ID).
- Undefined: no counter; timeout_err is tied to 0; the FSM waits indefinitely.

Test Plan:
- Send 0x42,0x07,0x03,0xAA,0xBB,0xCC with hdr_ready=pl_ready=1 -> header 42/07/03 accepted once; payload AA,BB,CC with pl_last only on CC; FSM returns to IDLE.
- Send 0x56,0x01,0x00 -> hdr_valid with len=0 one cycle after the len byte; no pl_valid; the next byte is parsed as a new type.
- FIFO_DEPTH=4, pl_ready=0, 6-byte payload -> 4 bytes stored, ovf_err=1; drain gives the first 4 bytes. Next frame parses correctly; err_clr clears ovf_err.
- hdr_ready=0, two back-to-back frames with len=2 -> second header dropped, its 2 bytes discarded via DROP, ovf_err=1. First header holds until accepted.
- With ICE_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 0x42,0x07 then idle 100 cycles -> timeout_err pulses once, state IDLE. A following full frame parses correctly.
- Assert reset mid-PAYLOAD with 2 bytes in the FIFO -> all outputs 0 immediately, FIFO empty. A frame after release parses correctly.
